jac_control_unit: RTL and testbench

Fetch/decode/execute sequencer for the Jac1-8 8-bit core, sitting directly upstream of the ALU. It fetches instructions from program memory over a req/valid handshake and holds a 4x8 register file. It drives the ALU opcode/operand/param inputs, writes back the ALU result and latches the ALU status into a status register. Program-flow opcodes (GOTO/IF*) are resolved here against that status register.

---
 rtl/jac_isa_pkg.sv | 57 +++++
 rtl/jac_regfile.sv | 29 ++
 rtl/jac_control_unit.sv | 115 +++++++++++
 tb/tb_jac_control_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jac_isa_pkg.sv
// Jac1-8 instruction set: widths, opcode map, status bit positions and
// instruction field slices shared by the control unit and register file.
package jac_isa_pkg;

  localparam int DataWidth     = 8;
  localparam int NumOpCodeBits = 5;
  localparam int ParamBits     = 8;
  localparam int NumStatusBits = 6;
  localparam int RegAddrBits   = 2;
  localparam int InstrWidth    = 17;
  localparam int NumRegs       = 1 << RegAddrBits;

  localparam int OpMsb    = 16;
  localparam int OpLsb    = 12;
  localparam int RaMsb    = 11;
  localparam int RaLsb    = 10;
  localparam int RbMsb    = 9;
  localparam int RbLsb    = 8;
  localparam int ParamMsb = 7;
  localparam int ParamLsb = 0;

  localparam int StC  = 0;
  localparam int StU  = 1;
  localparam int StZ  = 2;
  localparam int StEq = 3;
  localparam int StGt = 4;
  localparam int StSt = 5;

  localparam logic [NumOpCodeBits-1:0] Op_NOP  = 5'b0_0000;
  localparam logic [NumOpCodeBits-1:0] Op_ADD  = 5'b0_0001;
  localparam logic [NumOpCodeBits-1:0] Op_SUB  = 5'b0_0010;
  localparam logic [NumOpCodeBits-1:0] Op_AND  = 5'b0_0011;
  localparam logic [NumOpCodeBits-1:0] Op_OR   = 5'b0_0100;
  localparam logic [NumOpCodeBits-1:0] Op_NOT  = 5'b0_0101;
  localparam logic [NumOpCodeBits-1:0] Op_XOR  = 5'b0_0110;
  localparam logic [NumOpCodeBits-1:0] Op_SHL  = 5'b0_0111;
  localparam logic [NumOpCodeBits-1:0] Op_SHR  = 5'b0_1000;
  localparam logic [NumOpCodeBits-1:0] Op_VAL  = 5'b0_1001;
  localparam logic [NumOpCodeBits-1:0] Op_CMP  = 5'b0_1010;
  // ADDC/SUBU exist in the ALU but this sequencer never issues them.
  localparam logic [NumOpCodeBits-1:0] Op_ADDC = 5'b0_1011;
  localparam logic [NumOpCodeBits-1:0] Op_SUBU = 5'b0_1100;
  localparam logic [NumOpCodeBits-1:0] Op_GOTO = 5'b1_0000;
  localparam logic [NumOpCodeBits-1:0] Op_IFZ  = 5'b1_0001;
  localparam logic [NumOpCodeBits-1:0] Op_IFNZ = 5'b1_0010;
  localparam logic [NumOpCodeBits-1:0] Op_IFEQ = 5'b1_0011;
  localparam logic [NumOpCodeBits-1:0] Op_IFST = 5'b1_0100;
  localparam logic [NumOpCodeBits-1:0] Op_IFGT = 5'b1_0101;

  typedef enum logic {FETCH, EXEC} state_t;

  // Opcodes that are forwarded to the ALU during EXEC.
  function automatic logic is_alu_op(input logic [NumOpCodeBits-1:0] op);
    return ((op >= Op_ADD) && (op <= Op_SHR)) || (op == Op_CMP);
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// 4-entry register file: two asynchronous read ports, one synchronous write port.
module jac_regfile
  import jac_isa_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [RegAddrBits-1:0] rd_addr_a,
  output logic [DataWidth-1:0]   rd_data_a,
  input  logic [RegAddrBits-1:0] rd_addr_b,
  output logic [DataWidth-1:0]   rd_data_b,
  input  logic                   wr_en,
  input  logic [RegAddrBits-1:0] wr_addr,
  input  logic [DataWidth-1:0]   wr_data
);

  logic [DataWidth-1:0] regs [NumRegs];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 fetch/execute sequencer: fetches over req/valid, drives the ALU,
// writes back results and resolves GOTO/IF* against the latched status.
module jac_control_unit
  import jac_isa_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  output logic                     instr_req,
  output logic [ParamBits-1:0]     instr_addr,
  input  logic                     instr_valid,
  input  logic [InstrWidth-1:0]    instr_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] status_q,
  output logic                     retire
);

  state_t                   state, state_next;
  logic [ParamBits-1:0]     pc, pc_next;
  logic [InstrWidth-1:0]    ir;
  logic [NumOpCodeBits-1:0] op;
  logic [RegAddrBits-1:0]   ra, rb;
  logic [ParamBits-1:0]     param;
  logic [DataWidth-1:0]     rd_a, rd_b, wr_data;
  logic                     exec, drive, wr_en, status_we, taken;

  assign op    = ir[OpMsb:OpLsb];
  assign ra    = ir[RaMsb:RaLsb];
  assign rb    = ir[RbMsb:RbLsb];
  assign param = ir[ParamMsb:ParamLsb];
  assign exec  = (state == EXEC);

  jac_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_a (ra),
    .rd_data_a (rd_a),
    .rd_addr_b (rb),
    .rd_data_b (rd_b),
    .wr_en     (wr_en),
    .wr_addr   (ra),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_next = state;
    instr_req  = 1'b0;
    case (state)
      FETCH: begin
        instr_req = run;
        if (run && instr_valid) state_next = EXEC;
      end
      EXEC:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Idle ALU inputs are forced to zero so the ALU sees a NOP outside EXEC.
  assign drive        = exec && is_alu_op(op);
  assign alu_opcode   = drive ? op    : '0;
  assign alu_operand1 = drive ? rd_a  : '0;
  assign alu_operand2 = drive ? rd_b  : '0;
  assign alu_param    = drive ? param : '0;
  assign instr_addr   = pc;

  always_comb begin
    wr_en     = 1'b0;
    wr_data   = alu_result;
    status_we = 1'b0;
    taken     = 1'b0;
    if (exec) begin
      case (op)
        Op_ADD, Op_SUB, Op_AND, Op_OR, Op_NOT, Op_XOR, Op_SHL, Op_SHR: begin
          wr_en     = 1'b1;
          status_we = 1'b1;
        end
        Op_CMP:  status_we = 1'b1;
        Op_VAL: begin
          wr_en   = 1'b1;
          wr_data = param;
        end
        Op_GOTO: taken = 1'b1;
        Op_IFZ:  taken = status_q[StZ];
        Op_IFNZ: taken = !status_q[StZ];
        Op_IFEQ: taken = status_q[StEq];
        Op_IFST: taken = status_q[StSt];
        Op_IFGT: taken = status_q[StGt];
        default: ;
      endcase
    end
    pc_next = taken ? param : pc + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      status_q <= '0;
      retire   <= 1'b0;
    end else begin
      state  <= state_next;
      retire <= exec;
      if ((state == FETCH) && instr_req && instr_valid) ir <= instr_data;
      if (exec) pc <= pc_next;
      if (status_we) status_q <= alu_status;
    end
  end

endmodule

// File: tb/tb_jac_control_unit.sv
// Directed bench for jac_control_unit: vector tables of single instructions
// plus hand-written park, ignored-valid and mid-EXEC reset sequences.
module tb_jac_control_unit;
  import jac_isa_pkg::*;

  logic                     clock = 1'b0;
  logic                     reset, run, instr_valid;
  logic                     instr_req, retire;
  logic [ParamBits-1:0]     instr_addr, alu_param;
  logic [InstrWidth-1:0]    instr_data;
  logic [NumOpCodeBits-1:0] alu_opcode;
  logic [DataWidth-1:0]     alu_operand1, alu_operand2, alu_result;
  logic [NumStatusBits-1:0] alu_status, status_q;
  logic [8:0]               sum9;

  int total;
  int bad;

  typedef struct {
    logic [16:0] instr;
    int          stall;
    logic [4:0]  opc;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  prm;
    logic [7:0]  nxt;
    logic [5:0]  st;
  } vec_t;

  vec_t tab_a[17];
  vec_t tab_b[3];
  vec_t tab_c[1];

  always #5 clock = ~clock;

  jac_control_unit dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_param    (alu_param),
    .alu_result   (alu_result),
    .alu_status   (alu_status),
    .status_q     (status_q),
    .retire       (retire)
  );

  // Reduced ALU model: ADD with carry, CMP with EQ/GT, Z from the result.
  always_comb begin
    alu_result = '0;
    alu_status = '0;
    sum9       = '0;
    case (alu_opcode)
      Op_ADD: begin
        sum9            = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        alu_result      = sum9[7:0];
        alu_status[StC] = sum9[8];
      end
      Op_CMP: begin
        alu_result       = alu_operand1 - alu_operand2;
        alu_status[StEq] = (alu_operand1 == alu_operand2);
        alu_status[StGt] = (alu_operand1 > alu_operand2);
      end
      default: alu_result = alu_operand1;
    endcase
    if (alu_opcode != Op_NOP) alu_status[StZ] = (alu_result == 8'd0);
  end

  function automatic logic [16:0] mk(input logic [4:0] op, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic [7:0] p);
    return {op, ra, rb, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the retire cycle.
  task automatic run_vec(input string tag, input vec_t v);
    instr_valid = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clock); @(negedge clock);
      chk({tag, ".stall_req"},    32'(instr_req), 32'd1);
      chk({tag, ".stall_addr"},   32'(instr_addr), 32'(v.nxt == 8'h03 ? 8'h02 : instr_addr));
      chk({tag, ".stall_retire"}, 32'(retire), 32'd0);
      chk({tag, ".stall_opc"},    32'(alu_opcode), 32'd0);
    end
    instr_data  = v.instr;
    instr_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    instr_valid = 1'b0;
    chk({tag, ".opc"},      32'(alu_opcode), 32'(v.opc));
    chk({tag, ".op1"},      32'(alu_operand1), 32'(v.op1));
    chk({tag, ".op2"},      32'(alu_operand2), 32'(v.op2));
    chk({tag, ".param"},    32'(alu_param), 32'(v.prm));
    chk({tag, ".exec_req"}, 32'(instr_req), 32'd0);
    chk({tag, ".exec_ret"}, 32'(retire), 32'd0);
    @(posedge clock); @(negedge clock);
    chk({tag, ".retire"},   32'(retire), 32'd1);
    chk({tag, ".next_pc"},  32'(instr_addr), 32'(v.nxt));
    chk({tag, ".status"},   32'(status_q), 32'(v.st));
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    run         = 1'b0;
    instr_valid = 1'b0;
    instr_data  = '0;

    //                instr                          stall opc     op1    op2    prm    nxt    status
    tab_a[0]  = '{mk(Op_VAL, 2'd0, 2'd0, 8'h05), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h01, 6'h00};
    tab_a[1]  = '{mk(Op_VAL, 2'd1, 2'd0, 8'h03), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h02, 6'h00};
    tab_a[2]  = '{mk(Op_ADD, 2'd0, 2'd1, 8'h00), 3, Op_ADD, 8'd5,  8'd3,  8'h00, 8'h03, 6'h00};
    tab_a[3]  = '{mk(Op_CMP, 2'd0, 2'd1, 8'h00), 0, Op_CMP, 8'd8,  8'd3,  8'h00, 8'h04, 6'h10};
    tab_a[4]  = '{mk(Op_VAL, 2'd2, 2'd0, 8'h07), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h05, 6'h10};
    tab_a[5]  = '{mk(Op_VAL, 2'd3, 2'd0, 8'h07), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h06, 6'h10};
    tab_a[6]  = '{mk(Op_CMP, 2'd2, 2'd3, 8'h00), 0, Op_CMP, 8'd7,  8'd7,  8'h00, 8'h07, 6'h0C};
    tab_a[7]  = '{mk(Op_IFEQ, 2'd0, 2'd0, 8'h20), 0, Op_NOP, 8'd0, 8'd0,  8'h00, 8'h20, 6'h0C};
    tab_a[8]  = '{mk(Op_IFGT, 2'd0, 2'd0, 8'h40), 0, Op_NOP, 8'd0, 8'd0,  8'h00, 8'h21, 6'h0C};
    tab_a[9]  = '{mk(Op_IFZ, 2'd0, 2'd0, 8'h30), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h30, 6'h0C};
    tab_a[10] = '{mk(Op_IFNZ, 2'd0, 2'd0, 8'h50), 0, Op_NOP, 8'd0, 8'd0,  8'h00, 8'h31, 6'h0C};
    tab_a[11] = '{mk(Op_GOTO, 2'd0, 2'd0, 8'hFF), 0, Op_NOP, 8'd0, 8'd0,  8'h00, 8'hFF, 6'h0C};
    tab_a[12] = '{mk(Op_NOP, 2'd0, 2'd0, 8'h00), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h00, 6'h0C};
    tab_a[13] = '{mk(5'b0_1101, 2'd2, 2'd3, 8'h55), 0, Op_NOP, 8'd0, 8'd0, 8'h00, 8'h01, 6'h0C};
    tab_a[14] = '{mk(Op_ADD, 2'd2, 2'd3, 8'h5A), 0, Op_ADD, 8'd7,  8'd7,  8'h5A, 8'h02, 6'h00};
    tab_a[15] = '{mk(Op_IFST, 2'd0, 2'd0, 8'h10), 0, Op_NOP, 8'd0, 8'd0,  8'h00, 8'h03, 6'h00};
    tab_a[16] = '{mk(Op_ADD, 2'd2, 2'd2, 8'h00), 0, Op_ADD, 8'd14, 8'd14, 8'h00, 8'h04, 6'h00};

    tab_b[0]  = '{mk(Op_VAL, 2'd0, 2'd0, 8'h05), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h06, 6'h00};
    tab_b[1]  = '{mk(Op_VAL, 2'd1, 2'd0, 8'h03), 0, Op_NOP, 8'd0,  8'd0,  8'h00, 8'h07, 6'h00};
    tab_b[2]  = '{mk(Op_CMP, 2'd0, 2'd1, 8'h00), 0, Op_CMP, 8'd5,  8'd3,  8'h00, 8'h08, 6'h10};

    tab_c[0]  = '{mk(Op_ADD, 2'd0, 2'd1, 8'h00), 0, Op_ADD, 8'd0,  8'd0,  8'h00, 8'h01, 6'h04};

    @(negedge clock); @(negedge clock);
    chk("rst.addr",   32'(instr_addr), 32'd0);
    chk("rst.status", 32'(status_q), 32'd0);
    chk("rst.retire", 32'(retire), 32'd0);
    chk("rst.req",    32'(instr_req), 32'd0);
    chk("rst.opc",    32'(alu_opcode), 32'd0);
    reset = 1'b0;
    run   = 1'b1;
    #1;
    chk("run.req", 32'(instr_req), 32'd1);
    @(negedge clock);

    for (int i = 0; i < 17; i++) run_vec($sformatf("a%0d", i), tab_a[i]);

    // run dropped during EXEC: instruction completes, then parks with no request.
    instr_data  = mk(Op_NOP, 2'd0, 2'd0, 8'h00);
    instr_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    instr_valid = 1'b0;
    run         = 1'b0;
    chk("park.exec_ret", 32'(retire), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("park.retire", 32'(retire), 32'd1);
    chk("park.req",    32'(instr_req), 32'd0);
    chk("park.addr",   32'(instr_addr), 32'h05);
    instr_data  = mk(Op_GOTO, 2'd0, 2'd0, 8'h77);
    instr_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("ignore.req",    32'(instr_req), 32'd0);
    chk("ignore.retire", 32'(retire), 32'd0);
    chk("ignore.opc",    32'(alu_opcode), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("ignore.addr",   32'(instr_addr), 32'h05);
    instr_valid = 1'b0;
    run         = 1'b1;
    #1;
    chk("unpark.req", 32'(instr_req), 32'd1);
    @(negedge clock);

    for (int i = 0; i < 3; i++) run_vec($sformatf("b%0d", i), tab_b[i]);

    // Reset lands in the middle of ADD R0,R1: no writeback, state cleared at once.
    instr_data  = mk(Op_ADD, 2'd0, 2'd1, 8'h00);
    instr_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    instr_valid = 1'b0;
    chk("mid.opc", 32'(alu_opcode), 32'(Op_ADD));
    chk("mid.op1", 32'(alu_operand1), 32'd5);
    reset = 1'b1;
    #1;
    chk("mid.addr",   32'(instr_addr), 32'd0);
    chk("mid.status", 32'(status_q), 32'd0);
    chk("mid.opc0",   32'(alu_opcode), 32'd0);
    chk("mid.req",    32'(instr_req), 32'd1);
    @(posedge clock); @(negedge clock);
    chk("mid.retire", 32'(retire), 32'd0);
    chk("mid.addr2",  32'(instr_addr), 32'd0);
    reset = 1'b0;

    run_vec("c0", tab_c[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
